// File: rtl/uart_tx_cfg_if.sv
// Signal bundle between the debug-unit TX sequencer (master) and uart_tx_cfg (slave).
// The slave also publishes its FSM state on dbg_state for observation.
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8
);
    // Handshake: i_tx_start is a single-cycle request that is accepted only when
    // o_busy is low. There is no backpressure or queueing, so a request made while
    // o_busy is high is dropped. o_tx_done pulses once, in the cycle after the final
    // stop tick. A request made in that cycle is accepted.
    logic                               i_tick;
    logic                               i_tx_start;
    logic [DBIT_MAX-1:0]                i_data_in;
    logic [$clog2(DBIT_MAX+1)-1:0]      i_data_bits;
    logic [1:0]                         i_parity_mode;
    logic                               i_stop2;
    logic                               o_tx;
    logic                               o_busy;
    logic                               o_tx_done;
    logic [2:0]                         dbg_state;

    modport master (
        output i_tick, i_tx_start, i_data_in, i_data_bits, i_parity_mode, i_stop2,
        input  o_tx, o_busy, o_tx_done, dbg_state
    );

    modport slave (
        input  i_tick, i_tx_start, i_data_in, i_data_bits, i_parity_mode, i_stop2,
        output o_tx, o_busy, o_tx_done, dbg_state
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 1..DBIT_MAX data bits, optional parity, 1 or 2 stops.
// Parity support is compiled in only when UART_TX_CFG_PARITY_EN is defined.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int SB_TICK  = 16
) (
    input logic          i_clk,
    input logic          i_reset_n,
    uart_tx_cfg_if.slave bus
);

    localparam int DBW = $clog2(DBIT_MAX + 1);
    localparam int TCW = $clog2(2 * SB_TICK);
    localparam int BCW = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;

    localparam logic [TCW-1:0] TICK_LAST1 = TCW'(SB_TICK - 1);
    localparam logic [TCW-1:0] TICK_LAST2 = TCW'(2 * SB_TICK - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]          state;
    logic [TCW-1:0]      tick_cnt;
    logic [BCW-1:0]      bit_cnt;
    logic [BCW-1:0]      last_bit;
    logic [DBIT_MAX-1:0] shift;
    logic                stop2;
    logic                tx;
    logic                busy;
    logic                tx_done;

    logic                bit_end;
    logic                stop_end;
    logic [DBIT_MAX-1:0] shift_nx;
    logic [DBW-1:0]      nbits_in;
    logic                nbits_ok;
    logic [BCW-1:0]      last_sel;

    // The bit count is kept as the index of the final data bit. An illegal count falls back to DBIT_MAX.
    assign nbits_in = bus.i_data_bits;
    assign nbits_ok = (nbits_in != '0) && (nbits_in <= DBW'(DBIT_MAX));
    assign last_sel = nbits_ok ? BCW'(nbits_in - 1'b1) : BCW'(DBIT_MAX - 1);

    assign bit_end  = bus.i_tick && (tick_cnt == TICK_LAST1);
    assign stop_end = bus.i_tick && (tick_cnt == (stop2 ? TICK_LAST2 : TICK_LAST1));
    assign shift_nx = shift >> 1;

`ifdef UART_TX_CFG_PARITY_EN
    logic [1:0] par_mode;
    logic       par_acc;
    logic       acc_nx;
    logic       par_on;
    logic       par_bit;

    assign acc_nx  = par_acc ^ shift[0];
    assign par_on  = (par_mode == 2'b01) || (par_mode == 2'b10);
    assign par_bit = (par_mode == 2'b10) ? ~acc_nx : acc_nx;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^bus.i_parity_mode;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            shift    <= '0;
            stop2    <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
            par_mode <= 2'b00;
            par_acc  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (bus.i_tx_start) begin
                        shift    <= bus.i_data_in;
                        last_bit <= last_sel;
                        stop2    <= bus.i_stop2;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
`ifdef UART_TX_CFG_PARITY_EN
                        par_mode <= bus.i_parity_mode;
                        par_acc  <= 1'b0;
`endif
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else if (bus.i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        shift    <= shift_nx;
                        bit_cnt  <= bit_cnt + 1'b1;
`ifdef UART_TX_CFG_PARITY_EN
                        par_acc  <= acc_nx;
`endif
                        if (bit_cnt == last_bit) begin
`ifdef UART_TX_CFG_PARITY_EN
                            if (par_on) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shift_nx[0];
                        end
                    end else if (bus.i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_CFG_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else if (bus.i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    tx <= 1'b1;
                    if (stop_end) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_done  <= 1'b1;
                    end else if (bus.i_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_tx      = tx;
    assign bus.o_busy    = busy;
    assign bus.o_tx_done = tx_done;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboarded bench for uart_tx_cfg: the driver queues hand-computed frames and the
// monitor compares the captured line waveform at each o_tx_done.
module tb_uart_tx_cfg;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    uart_tx_cfg_if #(.DBIT_MAX(8)) bus ();

    uart_tx_cfg #(.DBIT_MAX(8), .SB_TICK(16)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Expected frame: [27:20] clocks per bit, [19:16] bit count, [15:0] line bits in send order
    logic [27:0] exp_q[$];
    logic        trace_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          done_cnt  = 0;
    int          tick_per  = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Tick generator: a one-cycle strobe every tick_per clocks
    initial begin
        int div;
        div = 0;
        bus.i_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_tick = (tick_per == 1) || (div == 0);
            div = (div + 1) % tick_per;
        end
    end

    // Monitor: record o_tx while busy, then score the frame on o_tx_done
    initial begin
        logic        done_prev;
        logic [27:0] e;
        logic [15:0] got_first, got_mid, got_last;
        int          bc, len, idx;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                trace_q.delete();
                done_prev = 1'b0;
            end else begin
                if (done_prev) check("done_one_cycle", {31'd0, bus.o_tx_done}, 32'd0);
                done_prev = bus.o_tx_done;
                if (bus.o_busy) trace_q.push_back(bus.o_tx);
                if (bus.o_tx_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e   = exp_q.pop_front();
                        bc  = int'(e[27:20]);
                        len = int'(e[19:16]);
                        got_first = '0;
                        got_mid   = '0;
                        got_last  = '0;
                        check("frame_len_clks", 32'(trace_q.size()), 32'(len * bc));
                        for (int k = 0; k < len; k++) begin
                            idx = k * bc;
                            if (idx + bc - 1 < trace_q.size()) begin
                                got_first[k] = trace_q[idx];
                                got_mid[k]   = trace_q[idx + bc / 2];
                                got_last[k]  = trace_q[idx + bc - 1];
                            end else begin
                                got_first[k] = 1'bx;
                                got_mid[k]   = 1'bx;
                                got_last[k]  = 1'bx;
                            end
                        end
                        check("bits_first", {16'd0, got_first}, {16'd0, e[15:0]});
                        check("bits_mid",   {16'd0, got_mid},   {16'd0, e[15:0]});
                        check("bits_last",  {16'd0, got_last},  {16'd0, e[15:0]});
                    end
                    trace_q.delete();
                    done_cnt++;
                end
            end
        end
    end

    task automatic set_inputs(input logic [7:0] d, input logic [3:0] nb,
                              input logic [1:0] pm, input logic s2);
        bus.i_data_in     = d;
        bus.i_data_bits   = nb;
        bus.i_parity_mode = pm;
        bus.i_stop2       = s2;
    endtask

    // Start a frame in a cycle that carries a tick, so every bit is exactly 16*tick_per clocks
    task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] pm,
                        input logic s2, input logic [15:0] bits, input logic [3:0] len,
                        input logic push);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #2;
            if (bus.i_tick) break;
        end
        set_inputs(d, nb, pm, s2);
        bus.i_tx_start = 1'b1;
        if (push) exp_q.push_back({8'(16 * tick_per), len, bits});
        @(posedge clk);
        #2;
        bus.i_tx_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", 32'(done_cnt >= target), 32'd1);
        repeat (3) @(posedge clk);
    endtask

`ifdef UART_TX_CFG_PARITY_EN
    localparam logic [15:0] F2_BITS = 16'h066A; localparam logic [3:0] F2_LEN = 4'd11;
    localparam logic [15:0] F3O_BITS = 16'h0402; localparam logic [3:0] F3_LEN = 4'd11;
    localparam logic [15:0] F3E_BITS = 16'h0602;
    localparam logic [15:0] FB_BITS = 16'h05E0; localparam logic [3:0] FB_LEN = 4'd11;
    localparam logic [15:0] F1B_BITS = 16'h000E; localparam logic [3:0] F1B_LEN = 4'd4;
`else
    localparam logic [15:0] F2_BITS = 16'h036A; localparam logic [3:0] F2_LEN = 4'd10;
    localparam logic [15:0] F3O_BITS = 16'h0202; localparam logic [3:0] F3_LEN = 4'd10;
    localparam logic [15:0] F3E_BITS = 16'h0202;
    localparam logic [15:0] FB_BITS = 16'h03E0; localparam logic [3:0] FB_LEN = 4'd10;
    localparam logic [15:0] F1B_BITS = 16'h0006; localparam logic [3:0] F1B_LEN = 4'd3;
`endif

    initial begin
        int  frames;
        logic seen;
        bus.i_tx_start = 1'b0;
        set_inputs(8'h00, 4'd8, 2'b00, 1'b0);
        frames = 0;

        #3 rst_n = 1'b0;
        #1;
        check("rst_tx",    {31'd0, bus.o_tx},      32'd1);
        check("rst_busy",  {31'd0, bus.o_busy},    32'd0);
        check("rst_done",  {31'd0, bus.o_tx_done}, 32'd0);
        check("rst_state", {29'd0, bus.dbg_state}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 8N1 0xA5, tick every clock
        send(8'hA5, 4'd8, 2'b00, 1'b0, 16'h034A, 4'd10, 1'b1);
        wait_done(++frames);

        // 7 data bits, even parity, two stop bits
        send(8'h35, 4'd7, 2'b01, 1'b1, F2_BITS, F2_LEN, 1'b1);
        wait_done(++frames);

        // Slow tick: odd then even parity on 0x01
        tick_per = 4;
        repeat (8) @(posedge clk);
        send(8'h01, 4'd8, 2'b10, 1'b0, F3O_BITS, F3_LEN, 1'b1);
        wait_done(++frames);
        send(8'h01, 4'd8, 2'b01, 1'b0, F3E_BITS, F3_LEN, 1'b1);
        wait_done(++frames);
        tick_per = 1;
        repeat (8) @(posedge clk);

        // Start pulse and config churn while busy must not disturb the frame
        send(8'h00, 4'd8, 2'b00, 1'b0, 16'h0200, 4'd10, 1'b1);
        repeat (50) @(posedge clk);
        #2;
        set_inputs(8'hFF, 4'd3, 2'b01, 1'b1);
        bus.i_tx_start = 1'b1;
        @(posedge clk);
        #2;
        bus.i_tx_start = 1'b0;
        wait_done(++frames);

        // Back-to-back: second start issued in the o_tx_done cycle
        send(8'h0F, 4'd8, 2'b00, 1'b1, 16'h061E, 4'd11, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (bus.o_tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_done_seen", {31'd0, seen}, 32'd1);
        set_inputs(8'hF0, 4'd8, 2'b01, 1'b0);
        bus.i_tx_start = 1'b1;
        exp_q.push_back({8'd16, FB_LEN, FB_BITS});
        @(posedge clk);
        #1;
        check("b2b_busy",      {31'd0, bus.o_busy}, 32'd1);
        check("b2b_start_bit", {31'd0, bus.o_tx},   32'd0);
        #1 bus.i_tx_start = 1'b0;
        frames += 2;
        wait_done(frames);

        // Reset during DATA of 0x5A aborts with no done pulse
        send(8'h5A, 4'd8, 2'b00, 1'b0, 16'h0000, 4'd0, 1'b0);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx",    {31'd0, bus.o_tx},      32'd1);
        check("abort_busy",  {31'd0, bus.o_busy},    32'd0);
        check("abort_done",  {31'd0, bus.o_tx_done}, 32'd0);
        check("abort_state", {29'd0, bus.dbg_state}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(frames));
        send(8'h5A, 4'd8, 2'b00, 1'b0, 16'h02B4, 4'd10, 1'b1);
        wait_done(++frames);

        // Out-of-range bit counts fall back to 8; parity mode 11 means none
        send(8'h81, 4'd0,  2'b00, 1'b0, 16'h0302, 4'd10, 1'b1);
        wait_done(++frames);
        send(8'h3C, 4'd9,  2'b00, 1'b0, 16'h0278, 4'd10, 1'b1);
        wait_done(++frames);
        send(8'h3C, 4'd15, 2'b11, 1'b0, 16'h0278, 4'd10, 1'b1);
        wait_done(++frames);

        // Single data bit with even parity
        send(8'h01, 4'd1, 2'b01, 1'b0, F1B_BITS, F1B_LEN, 1'b1);
        wait_done(++frames);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter. It is the parametrised successor to the fixed 8N1 transmitter in the debug-unit UART path. Frame format (data bits, parity, stop bits) is selectable per frame, and bit timing is paced by the shared baud-rate tick generator (i_tick, SB_TICK ticks per bit). It sits between the debug-unit TX sequencer and the UART pin.

Parameters:
DBIT_MAX, 8, maximum data bits per frame; also the width of i_data_in.
SB_TICK, 16, i_tick pulses per bit period (oversampling factor); must be >= 2.

Ports:
i_clk  in  1  system clock; all state changes on its rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_tick  in  1  baud oversample strobe, one i_clk cycle wide.
i_tx_start  in  1  request to send i_data_in; sampled only in IDLE.
i_data_in  in  DBIT_MAX  payload, LSB transmitted first.
i_data_bits  in  $clog2(DBIT_MAX+1)  data bits for this frame; legal range 1..DBIT_MAX.
i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
i_stop2  in  1  0 = one stop bit, 1 = two stop bits.
o_tx  out  1  serial line output, registered, idle high.
o_busy  out  1  high while a frame is in progress.
o_tx_done  out  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - state=IDLE, o_tx=1, o_busy=0, o_tx_done=0.
  - tick counter, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; o_tx returns high with no done pulse.
- Registers: state, tick counter (width $clog2(2*SB_TICK)), bit counter (width $clog2(DBIT_MAX)), shift register (DBIT_MAX), latched config (data bits, parity mode, stop2), parity accumulator, o_tx, o_tx_done. All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1.
  - On i_tx_start=1, at the same edge: latch i_data_in and all config inputs, clear the counters, go to START, set o_tx=0 and o_busy=1.
  - A value of i_data_bits outside 1..DBIT_MAX is latched as DBIT_MAX.
- START: o_tx=0. After SB_TICK ticks go to DATA.
- DATA:
  - o_tx = shift[0].
  - On the SB_TICK-th tick of each bit: shift right, XOR the sent bit into the parity accumulator, increment the bit counter.
  - After the latched data-bit count of bits: go to PARITY if parity mode is 01 or 10, else go to STOP.
- PARITY:
  - even mode: o_tx = accumulator.
  - odd mode: o_tx = ~accumulator.
  - Lasts SB_TICK ticks, then go to STOP.
- STOP:
  - o_tx=1.
  - Lasts SB_TICK ticks, or 2*SB_TICK if stop2 is latched.
  - At the edge sampling the final tick: go to IDLE, o_busy=0, o_tx_done=1 for exactly one cycle.
- Tick counting:
  - Counters advance only on cycles with i_tick=1.
  - A bit ends, and the next bit value appears on o_tx, at the edge that samples its SB_TICK-th tick.
- Frame length: (1 + N + P + S) * SB_TICK ticks, where N = data bits, P = 1 if parity is enabled else 0, S = number of stop bits.
- Start handling:
  - i_tx_start while busy is ignored (not queued).
  - i_tx_start asserted in the cycle o_tx_done is high is accepted, giving back-to-back frames with no extra idle bit.
- Config and data inputs may change freely while busy; only the values latched at start are used.

Optional Feature:
Macro UART_TX_CFG_PARITY_EN.
- Defined: PARITY state and accumulator are present, and i_parity_mode behaves as above.
- Undefined:
  - PARITY state, accumulator and its logic are not synthesised.
  - i_parity_mode is still present as a port but ignored; frames are always no-parity (DATA goes straight to STOP).

Test Plan:
1. SB_TICK=16, i_tick every cycle, 0xA5, 8 bits, no parity, 1 stop -> o_tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; o_tx_done pulses once, 160 cycles after start; o_busy high for exactly those 160 cycles.
2. 0x35, 7 bits, even parity, 2 stop -> data 1,0,1,0,1,1,0, parity 0, stop high for 32 ticks; with macro undefined -> no parity bit, frame 160 ticks.
3. 0x01, 8 bits: odd parity -> parity bit 0; even parity -> parity bit 1. Checked with i_tick once every 4 clocks (bit period 64 clocks).
4. i_tx_start re-pulsed with 0xFF mid-frame of 0x00 -> ignored, the 0x00 frame is unchanged. Start asserted in the o_tx_done cycle -> next start bit begins at that edge with no idle gap.
5. i_reset_n low during DATA of frame 0x5A -> o_tx=1, o_busy=0 immediately, no o_tx_done. A new start after reset release -> a clean, correct frame.
6. i_data_bits=0 and i_data_bits=DBIT_MAX+1 (when representable) -> frame uses DBIT_MAX data bits.
